// File: rtl/wash_fault_monitor.sv
// wash_fault_monitor
//
// Supervises the fill, drain and spin phases of the washing-machine controller.
// It runs beside the main wash FSM, which supplies the current phase and the raw
// sensor values. The monitor returns phase-complete flags, a spin-hold request
// and latched error LEDs.
//
// Ports:
//   clk, reset            - system clock and synchronous active-high reset
//   phase                 - 00 idle, 01 fill, 10 drain, 11 spin
//   pause                 - freezes state, counters and outputs while high
//   continue_signal       - releases spin_hold after a vibration event
//   clear_errors          - clears latched faults and returns to IDLE
//   target_level          - fill-complete threshold (unsigned)
//   empty_level           - drain-complete threshold (unsigned)
//   water_level_sensor    - current water level (unsigned)
//   vibration_sensor      - 1 = excessive drum vibration
//   fill_done, drain_done - level condition met in the current phase
//   spin_hold             - request to stop the drum motor
//   water_flow_error_led  - latched fill timeout
//   drainage_error_led    - latched drain timeout
//   vibration_error_led   - latched vibration retry overflow
//   fault                 - OR of the three error LEDs
module wash_fault_monitor #(
  parameter int SENSOR_W      = 10,
  parameter int CNT_W         = 8,
  parameter int FILL_TIMEOUT  = 20,
  parameter int DRAIN_TIMEOUT = 20,
  parameter int VIB_DEBOUNCE  = 3,
  parameter int VIB_RETRY_MAX = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          phase,
  input  logic                pause,
  input  logic                continue_signal,
  input  logic                clear_errors,
  input  logic [SENSOR_W-1:0] target_level,
  input  logic [SENSOR_W-1:0] empty_level,
  input  logic [SENSOR_W-1:0] water_level_sensor,
  input  logic                vibration_sensor,
  output logic                fill_done,
  output logic                drain_done,
  output logic                spin_hold,
  output logic                water_flow_error_led,
  output logic                drainage_error_led,
  output logic                vibration_error_led,
  output logic                fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILLING,
    S_FILL_OK,
    S_DRAINING,
    S_DRAIN_OK,
    S_SPIN_RUN,
    S_SPIN_HOLD,
    S_FAULT
  } state_t;

  localparam logic [1:0] PH_FILL  = 2'b01;
  localparam logic [1:0] PH_DRAIN = 2'b10;
  localparam logic [1:0] PH_SPIN  = 2'b11;

  // A timeout fires when the counter already holds TIMEOUT-1 and the level is
  // still not met, so the fault lands exactly TIMEOUT active cycles after entry.
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] VIB_LIMIT  = CNT_W'(VIB_DEBOUNCE);
  localparam logic [CNT_W-1:0] RETRY_MAX  = CNT_W'(VIB_RETRY_MAX);

  state_t            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  vib_cnt_q, vib_cnt_d;
  logic [CNT_W-1:0]  retry_q, retry_d;
  logic              wf_err_q, wf_err_d;
  logic              dr_err_q, dr_err_d;
  logic              vib_err_q, vib_err_d;
  logic              fill_done_q, fill_done_d;
  logic              drain_done_q, drain_done_d;
  logic              spin_hold_q, spin_hold_d;
  logic              fault_q, fault_d;

  logic [CNT_W-1:0]  vib_next;
  logic [CNT_W-1:0]  retry_next;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Next-state logic. clear_errors beats pause, and pause beats everything
  // else. A phase change out of any working state goes through IDLE for one
  // cycle so that every new phase starts with fresh counters.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    vib_cnt_d  = vib_cnt_q;
    retry_d    = retry_q;
    wf_err_d   = wf_err_q;
    dr_err_d   = dr_err_q;
    vib_err_d  = vib_err_q;
    vib_next   = sat_inc(vib_cnt_q);
    retry_next = sat_inc(retry_q);

    if (clear_errors) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      vib_cnt_d = '0;
      retry_d   = '0;
      wf_err_d  = 1'b0;
      dr_err_d  = 1'b0;
      vib_err_d = 1'b0;
    end else if (!pause) begin
      if (state_q == S_IDLE) begin
        cnt_d     = '0;
        vib_cnt_d = '0;
        retry_d   = '0;
        phase_d   = phase;
        case (phase)
          PH_FILL:  state_d = S_FILLING;
          PH_DRAIN: state_d = S_DRAINING;
          PH_SPIN:  state_d = S_SPIN_RUN;
          default:  state_d = S_IDLE;
        endcase
      end else if (state_q != S_FAULT) begin
        if (phase != phase_q) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          vib_cnt_d = '0;
          retry_d   = '0;
        end else begin
          case (state_q)
            S_FILLING: begin
              if (water_level_sensor >= target_level) begin
                state_d = S_FILL_OK;
              end else if (cnt_q == FILL_LAST) begin
                state_d  = S_FAULT;
                wf_err_d = 1'b1;
              end else begin
                cnt_d = sat_inc(cnt_q);
              end
            end
            S_DRAINING: begin
              if (water_level_sensor <= empty_level) begin
                state_d = S_DRAIN_OK;
              end else if (cnt_q == DRAIN_LAST) begin
                state_d  = S_FAULT;
                dr_err_d = 1'b1;
              end else begin
                cnt_d = sat_inc(cnt_q);
              end
            end
            // A vibration event needs VIB_DEBOUNCE consecutive high samples.
            // Each event uses up one retry. Once the retries are exhausted,
            // the event becomes a hard fault instead of a hold.
            S_SPIN_RUN: begin
              if (vibration_sensor) begin
                vib_cnt_d = vib_next;
                if (vib_next >= VIB_LIMIT) begin
                  retry_d = retry_next;
                  if (retry_next > RETRY_MAX) begin
                    state_d   = S_FAULT;
                    vib_err_d = 1'b1;
                  end else begin
                    state_d = S_SPIN_HOLD;
                  end
                end
              end else begin
                vib_cnt_d = '0;
              end
            end
            S_SPIN_HOLD: begin
              if (continue_signal) begin
                state_d   = S_SPIN_RUN;
                vib_cnt_d = '0;
              end
            end
            default: state_d = state_q;
          endcase
        end
      end
    end

    fill_done_d  = (state_d == S_FILL_OK);
    drain_done_d = (state_d == S_DRAIN_OK);
    spin_hold_d  = (state_d == S_SPIN_HOLD);
    fault_d      = wf_err_d | dr_err_d | vib_err_d;
  end

  // State, counters, latches and registered outputs. Reset overrides pause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= 2'b00;
      cnt_q        <= '0;
      vib_cnt_q    <= '0;
      retry_q      <= '0;
      wf_err_q     <= 1'b0;
      dr_err_q     <= 1'b0;
      vib_err_q    <= 1'b0;
      fill_done_q  <= 1'b0;
      drain_done_q <= 1'b0;
      spin_hold_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      vib_cnt_q    <= vib_cnt_d;
      retry_q      <= retry_d;
      wf_err_q     <= wf_err_d;
      dr_err_q     <= dr_err_d;
      vib_err_q    <= vib_err_d;
      fill_done_q  <= fill_done_d;
      drain_done_q <= drain_done_d;
      spin_hold_q  <= spin_hold_d;
      fault_q      <= fault_d;
    end
  end

  assign fill_done            = fill_done_q;
  assign drain_done           = drain_done_q;
  assign spin_hold            = spin_hold_q;
  assign water_flow_error_led = wf_err_q;
  assign drainage_error_led   = dr_err_q;
  assign vibration_error_led  = vib_err_q;
  assign fault                = fault_q;

endmodule

// File: tb/tb_wash_fault_monitor.sv
// tb_wash_fault_monitor
//
// Self-checking bench for wash_fault_monitor with default parameters.
// Each scenario task pushes the expected output vector for an edge onto a
// scoreboard queue while it drives that edge's inputs. After the edge it pops
// the entry and compares it with the DUT outputs.
// Vector order: {fill_done, drain_done, spin_hold, wf_led, dr_led, vib_led, fault}.
module tb_wash_fault_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] phase;
  logic       pause;
  logic       continue_signal;
  logic       clear_errors;
  logic [9:0] target_level;
  logic [9:0] empty_level;
  logic [9:0] water_level_sensor;
  logic       vibration_sensor;
  logic       fill_done, drain_done, spin_hold;
  logic       water_flow_error_led, drainage_error_led, vibration_error_led, fault;

  typedef struct {
    string      tag;
    logic [6:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [6:0] obs;
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_FILL   = 7'b1000000;
  localparam logic [6:0] O_DRAIN  = 7'b0100000;
  localparam logic [6:0] O_HOLD   = 7'b0010000;
  localparam logic [6:0] O_WF_ERR = 7'b0001001;
  localparam logic [6:0] O_DR_ERR = 7'b0000101;
  localparam logic [6:0] O_VB_ERR = 7'b0000011;

  wash_fault_monitor dut (
    .clk                  (clk),
    .reset                (reset),
    .phase                (phase),
    .pause                (pause),
    .continue_signal      (continue_signal),
    .clear_errors         (clear_errors),
    .target_level         (target_level),
    .empty_level          (empty_level),
    .water_level_sensor   (water_level_sensor),
    .vibration_sensor     (vibration_sensor),
    .fill_done            (fill_done),
    .drain_done           (drain_done),
    .spin_hold            (spin_hold),
    .water_flow_error_led (water_flow_error_led),
    .drainage_error_led   (drainage_error_led),
    .vibration_error_led  (vibration_error_led),
    .fault                (fault)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it, away from the clock edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    reset = 1'b0; pause = 1'b0; continue_signal = 1'b0; vibration_sensor = 1'b0;
    phase = 2'b00; clear_errors = 1'b1;
    cycle();
    clear_errors = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; phase = 2'b01; pause = 1'b0; continue_signal = 1'b0;
    clear_errors = 1'b0; target_level = 10'd300; empty_level = 10'd0;
    water_level_sensor = 10'd0; vibration_sensor = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      sb.push_back('{"reset", O_NONE});
      cycle();
      e = sb.pop_front();
      obs = {fill_done, drain_done, spin_hold, water_flow_error_led,
             drainage_error_led, vibration_error_led, fault};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, i, obs, e.val);
      end
    end
    reset = 1'b0;
    phase = 2'b00;
  endtask

  task automatic test_fill_ok();
    go_idle();
    target_level = 10'd300;
    phase = 2'b01;
    for (int i = 1; i <= 11; i++) begin
      water_level_sensor = (i >= 7) ? 10'd300 : 10'd200;
      if (i == 11) phase = 2'b00;
      sb.push_back('{"fill_ok", (i >= 7 && i <= 10) ? O_FILL : O_NONE});
      cycle();
      e = sb.pop_front();
      obs = {fill_done, drain_done, spin_hold, water_flow_error_led,
             drainage_error_led, vibration_error_led, fault};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, i, obs, e.val);
      end
    end
  endtask

  // The timeout lands 20 edges after FILLING entry. The fault holds across a
  // phase change and is released by clear_errors, even with the fill phase
  // still requested.
  task automatic test_fill_timeout();
    go_idle();
    target_level = 10'd300;
    water_level_sensor = 10'd200;
    for (int i = 1; i <= 27; i++) begin
      phase = (i == 23 || i == 24) ? 2'b00 : 2'b01;
      clear_errors = (i == 25);
      sb.push_back('{"fill_timeout", (i >= 21 && i <= 24) ? O_WF_ERR : O_NONE});
      cycle();
      e = sb.pop_front();
      obs = {fill_done, drain_done, spin_hold, water_flow_error_led,
             drainage_error_led, vibration_error_led, fault};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, i, obs, e.val);
      end
    end
    clear_errors = 1'b0;
  endtask

  // There are 10 paused edges in the middle of the drain, so the timeout
  // moves from edge 21 to edge 31.
  task automatic test_drain_pause();
    go_idle();
    empty_level = 10'd0;
    water_level_sensor = 10'd300;
    phase = 2'b10;
    for (int i = 1; i <= 33; i++) begin
      pause = (i >= 6 && i <= 15);
      sb.push_back('{"drain_pause", (i >= 31) ? O_DR_ERR : O_NONE});
      cycle();
      e = sb.pop_front();
      obs = {fill_done, drain_done, spin_hold, water_flow_error_led,
             drainage_error_led, vibration_error_led, fault};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, i, obs, e.val);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_vibration();
    go_idle();
    phase = 2'b11;
    for (int i = 1; i <= 11; i++) begin
      vibration_sensor = (i == 2 || i == 3 || (i >= 5 && i <= 7));
      continue_signal  = (i == 10);
      sb.push_back('{"vibration", (i >= 7 && i <= 9) ? O_HOLD : O_NONE});
      cycle();
      e = sb.pop_front();
      obs = {fill_done, drain_done, spin_hold, water_flow_error_led,
             drainage_error_led, vibration_error_led, fault};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, i, obs, e.val);
      end
    end
    continue_signal = 1'b0;
    vibration_sensor = 1'b0;
  endtask

  task automatic test_vib_fault();
    logic [6:0] x;
    go_idle();
    for (int i = 1; i <= 14; i++) begin
      phase = (i >= 13) ? 2'b00 : 2'b11;
      vibration_sensor = (i >= 2 && i <= 4) || (i >= 6 && i <= 8) || (i >= 10 && i <= 12);
      continue_signal  = (i == 5 || i == 9);
      x = (i == 4 || i == 8) ? O_HOLD : ((i >= 12) ? O_VB_ERR : O_NONE);
      sb.push_back('{"vib_fault", x});
      cycle();
      e = sb.pop_front();
      obs = {fill_done, drain_done, spin_hold, water_flow_error_led,
             drainage_error_led, vibration_error_led, fault};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, i, obs, e.val);
      end
    end
    continue_signal = 1'b0;
    vibration_sensor = 1'b0;
  endtask

  // At edge 17 the counter is at 15 and reset arrives with pause also high.
  // Restarting from edge 18 must put the timeout at edge 38.
  task automatic test_reset_mid_fill();
    go_idle();
    target_level = 10'd300;
    water_level_sensor = 10'd200;
    phase = 2'b01;
    for (int i = 1; i <= 40; i++) begin
      reset = (i == 17);
      pause = (i == 17);
      sb.push_back('{"reset_mid_fill", (i >= 38) ? O_WF_ERR : O_NONE});
      cycle();
      e = sb.pop_front();
      obs = {fill_done, drain_done, spin_hold, water_flow_error_led,
             drainage_error_led, vibration_error_led, fault};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, i, obs, e.val);
      end
    end
    reset = 1'b0;
    pause = 1'b0;
  endtask

  // A level that already meets the threshold on entry finishes on the first
  // evaluation, and equality counts for both fill and drain.
  task automatic test_back_to_back();
    logic [6:0] x;
    go_idle();
    target_level = 10'd300;
    empty_level = 10'd300;
    water_level_sensor = 10'd300;
    for (int i = 1; i <= 6; i++) begin
      phase = (i <= 2) ? 2'b01 : 2'b10;
      x = (i == 2) ? O_FILL : ((i >= 5) ? O_DRAIN : O_NONE);
      sb.push_back('{"back_to_back", x});
      cycle();
      e = sb.pop_front();
      obs = {fill_done, drain_done, spin_hold, water_flow_error_led,
             drainage_error_led, vibration_error_led, fault};
      n_cmp++;
      if (obs !== e.val) begin
        n_bad++;
        $display("[TB] FAIL %s edge %0d: got %b expected %b", e.tag, i, obs, e.val);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill_ok();
    test_fill_timeout();
    test_drain_pause();
    test_vibration();
    test_vib_fault();
    test_reset_mid_fill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wash_fault_monitor.md
# wash_fault_monitor

Parametrised fill/drain/vibration supervisor for the washing-machine controller; replaces the single fixed-timeout water-flow monitor. Sits beside the main wash FSM, receives the current wash phase and raw sensor values, and returns phase-complete flags, a spin-hold request and latched error LEDs. Timeouts, debounce depth, retry limit and sensor width are parameters. Counters freeze while paused.

## Interface
- SENSOR_W, 10, width of water level sensor and level thresholds
- CNT_W, 8, width of internal timeout counter
- FILL_TIMEOUT, 20, cycles allowed for level to reach target_level during fill
- DRAIN_TIMEOUT, 20, cycles allowed for level to fall to empty_level during drain
- VIB_DEBOUNCE, 3, consecutive high vibration samples that count as one vibration event
- VIB_RETRY_MAX, 2, vibration events tolerated per spin phase before a hard fault
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- phase  input  2  00 idle, 01 fill, 10 drain, 11 spin
- pause  input  1  freezes all counters and state while high
- continue_signal  input  1  releases spin_hold after a vibration event
- clear_errors  input  1  clears latched faults, returns to IDLE
- target_level  input  SENSOR_W  fill-complete threshold
- empty_level  input  SENSOR_W  drain-complete threshold
- water_level_sensor  input  SENSOR_W  current level
- vibration_sensor  input  1  1 = excessive vibration
- fill_done  output  1  level reached target in current fill phase
- drain_done  output  1  level at/below empty_level in current drain phase
- spin_hold  output  1  request drum motor stop
- water_flow_error_led  output  1  latched fill timeout
- drainage_error_led  output  1  latched drain timeout
- vibration_error_led  output  1  latched vibration retry overflow
- fault  output  1  OR of the three error LEDs

## Operation
- States: IDLE, FILLING, FILL_OK, DRAINING, DRAIN_OK, SPIN_RUN, SPIN_HOLD, FAULT.
- Priority each cycle: reset > clear_errors > pause > normal transition.
- IDLE: counter=0, retry=0; phase 01 -> FILLING, 10 -> DRAINING, 11 -> SPIN_RUN.
- FILLING: level >= target_level -> FILL_OK; else counter+1; counter == FILL_TIMEOUT-1 with level still below -> FAULT, set water_flow_error_led.
- DRAINING: level <= empty_level -> DRAIN_OK; else counter+1; timeout at DRAIN_TIMEOUT-1 -> FAULT, set drainage_error_led.
- FILL_OK / DRAIN_OK: hold done flag; stay while phase unchanged.
- SPIN_RUN: vibration debounce counter increments on vibration_sensor=1, clears on 0; reaching VIB_DEBOUNCE -> retry+1; if new retry > VIB_RETRY_MAX -> FAULT, set vibration_error_led; else -> SPIN_HOLD.
- SPIN_HOLD: spin_hold=1; continue_signal=1 -> SPIN_RUN, debounce counter cleared.
- Any non-FAULT state: phase differs from the phase that entered it -> IDLE for one cycle (counters cleared), then dispatch. Level already satisfied on entry gives done on first evaluation.
- FAULT: sticky; ignores phase, pause, continue_signal; left only via clear_errors or reset (LEDs cleared, -> IDLE).
- Comparisons unsigned, full SENSOR_W. Counters saturate, never wrap; parameters must fit CNT_W (FILL_TIMEOUT, DRAIN_TIMEOUT < 2^CNT_W).

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- All outputs registered; decoded from state/latches, valid the cycle after the causing edge.
- Phase change to fill: IDLE->FILLING at edge 1; fill_done at earliest one cycle after the level condition is sampled true in FILLING.
- Fill timeout: water_flow_error_led rises FILL_TIMEOUT cycles after entering FILLING (pause cycles excluded).
- Vibration: spin_hold rises the cycle after the VIB_DEBOUNCE-th consecutive high sample; falls the cycle after continue_signal sampled high.
- pause high: state, counters, outputs held exactly; no sampling of sensors.
- clear_errors and a new phase on the same edge: clear wins, next dispatch from IDLE.
- reset mid-operation: all state and latches cleared on that edge regardless of pause.

## Test plan
- Defaults, phase=01, target=300, level 200 then 300 after 6 cycles -> fill_done=1 within 1 cycle of 300 sample, no error LED.
- phase=01, target=300, level held 200 -> water_flow_error_led=1 and fault=1 exactly 20 cycles after FILLING entry; clear_errors pulse -> both 0 next cycle.
- phase=10, empty=0, level held 300, pause high for 10 cycles mid-drain -> drainage_error_led at 30 cycles (20 active + 10 paused), not 20.
- phase=11, vibration 1 for 2 cycles then 0 -> no spin_hold; vibration 1 for 3 cycles -> spin_hold=1; continue_signal -> spin_hold=0.
- phase=11, three debounced vibration events with continue between -> third sets vibration_error_led=1, spin_hold=0, FAULT sticky across phase change to 00.
- Reset asserted during FILLING at counter=15 -> all outputs 0 next cycle; after release, phase=01 restarts count from 0.
